serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial 8-bit subtractor with borrow-in. Computes in_a - in_b - in_bin, LSB first, one bit per clock.
- It is the inverse-operation counterpart to the parallel full-adder cells in the ALU datapath.
- Used by the ALU's low-area SUB/CMP path; it returns the difference, final borrow, signed overflow and zero flags.
- Operation is controlled by a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits. The counter covers WIDTH steps; tests use 8.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_start  input  1  one-cycle request; sampled only when the block accepts a command.
- in_a  input  WIDTH  minuend; sampled with in_start.
- in_b  input  WIDTH  subtrahend; sampled with in_start.
- in_bin  input  1  borrow-in; sampled with in_start.
- diff_out  output  WIDTH  registered difference; holds the last result.
- b_out  output  1  final borrow (1 = unsigned a < b + bin); holds.
- ovf_out  output  1  signed two's-complement overflow; holds.
- zero_out  output  1  high when diff_out == 0; holds.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the results update.

Behaviour:
- Reset: a synchronous reset with rst=1 at any edge forces the following.
  - State becomes IDLE.
  - diff_out=0, b_out=0, ovf_out=0, zero_out=0, busy=0, done=0.
  - Internal shift registers, borrow and counter are cleared.
  - Reset mid-operation abandons the operation; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_start=1 at edge E0: latch a, b, bin into shift registers; borrow register <= in_bin; count <= 0.
  - Go to SHIFT; busy=1 from the cycle after E0.
- SHIFT: at each edge E1..E8, process bit i = count.
  - d = a[i] ^ b[i] ^ br.
  - br_next = (~a[i] & b[i]) | (~a[i] & br) | (b[i] & br).
  - Shift d into the MSB of the result register (right-shift), shift the operand registers right, count+1.
  - At E8 (count == WIDTH-1): commit outputs, go to DONE.
    - diff_out <= completed result.
    - b_out <= br_next.
    - ovf_out <= (a[7] != b[7]) && (d[7] != a[7]), using the latched a and b.
    - zero_out <= (result == 0).
    - busy <= 0; done <= 1.
- DONE: done=1 for exactly the cycle after E8.
  - At E9: done <= 0.
  - If in_start=1 at E9, the new command is accepted exactly as in IDLE (back-to-back, so the next operation starts immediately). Otherwise go to IDLE.
- Latency: done asserted 8 edges after the accepting edge. Throughput: one result per 9 cycles.
- in_start while in SHIFT is ignored: no effect on operands, counter or outputs.
- Operand inputs may change freely after the accepting edge; only the latched values are used.
- Result outputs change only at the commit edge (or reset). They are stable at all other times, including during a following operation.
- Borrow semantics: in_bin=1 subtracts an extra 1. Unsigned wrap-around is modulo 2^WIDTH, and b_out reports the wrap.

Test Plan:
- Reset, then a=0x05, b=0x03, bin=0, start pulse -> busy for 8 cycles; done pulse 8 edges later; diff=0x02, b_out=0, ovf=0, zero=0.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, b_out=1, ovf=0, zero=0. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, b_out=1, ovf=0.
- a=0x80, b=0x01 -> diff=0x7F, ovf=1, b_out=0. Then a=0x7F, b=0xFF -> diff=0x80, ovf=1, b_out=1.
- a=0x2A, b=0x2A, bin=0 -> diff=0x00, zero=1, b_out=0. Hold in_start high during the done cycle with a=0x10, b=0x01 -> accepted back-to-back; next done gives diff=0x0F, zero=0.
- Start a=0x05, b=0x03. Mid-SHIFT, pulse start with a=0xFF, b=0x00 -> ignored; result is 0x02 and done is still 8 edges after the first start. Previous outputs are held unchanged until that commit edge.
- Start an operation, assert rst at the 4th SHIFT cycle -> the next cycle shows all outputs 0 and state IDLE; no done pulse. A new start afterwards completes normally.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes in_a - in_b - in_bin LSB first, one bit per
// clock. It reports the difference, the final borrow, signed overflow and
// zero flags through a start/busy/done handshake. Requires WIDTH >= 2.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic [WIDTH-1:0] diff_out,
  output logic             b_out,
  output logic             ovf_out,
  output logic             zero_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             a_bit, b_bit, d_bit, br_nxt;
  logic [WIDTH-1:0] res_nxt;

  // One bit of the full subtractor, fed from the LSBs of the operand registers
  always_comb begin
    a_bit   = a_sr_q[0];
    b_bit   = b_sr_q[0];
    d_bit   = a_bit ^ b_bit ^ br_q;
    br_nxt  = (~a_bit & b_bit) | (~a_bit & br_q) | (b_bit & br_q);
    res_nxt = {d_bit, res_q[WIDTH-1:1]};
  end

  // Next-state and next-output computation for the handshake FSM
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    br_d    = br_q;
    count_d = count_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q == SHIFT) begin
      a_sr_d  = a_sr_q >> 1;
      b_sr_d  = b_sr_q >> 1;
      res_d   = res_nxt;
      br_d    = br_nxt;
      count_d = count_q + CW'(1);
      if (count_q == LAST) begin
        // On the last step the operand LSBs are the original sign bits
        diff_d  = res_nxt;
        bo_d    = br_nxt;
        ovf_d   = (a_bit != b_bit) && (d_bit != a_bit);
        zero_d  = (res_nxt == '0);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
    end else begin
      // IDLE and DONE accept a command identically, giving back-to-back issue
      if (in_start) begin
        a_sr_d  = in_a;
        b_sr_d  = in_b;
        br_d    = in_bin;
        res_d   = '0;
        count_d = '0;
        busy_d  = 1'b1;
        state_d = SHIFT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      count_q <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      br_q    <= br_d;
      count_q <= count_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign diff_out = diff_q;
  assign b_out    = bo_q;
  assign ovf_out  = ovf_q;
  assign zero_out = zero_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
